bcd_digit_packer: RTL and testbench
===================================

// Module: bcd_digit_packer
// PURPOSE
//   Downstream of the BCD 5311->8421 converter. Collects a stream of 8421 digits over a
//   valid/ready handshake into one packed multi-digit BCD word, MS digit first.
//   Checks every digit for range (0..9) and presents each completed frame to the next
//   stage (display/arithmetic) with valid/ready.
// PARAMETERS
//   NDIG  4  digits per frame (>=1); frame closes at NDIG digits or on in_last
// PORTS
//   clk        in   1          clock; all logic on rising edge
//   rst_n      in   1          synchronous reset, active low
//   in_digit   in   4          8421 BCD digit from converter
//   in_valid   in   1          in_digit valid
//   in_last    in   1          final digit of frame (qualified by in_valid)
//   in_ready   out  1          packer can accept a digit
//   out_word   out  4*NDIG     packed BCD, digit 0 in [3:0] = last received
//   out_count  out  CW         digits in frame, CW=$clog2(NDIG+1)
//   out_err    out  1          frame contained >=1 invalid digit (>9)
//   out_valid  out  1          out_word/out_count/out_err valid
//   out_ready  in   1          downstream accepts frame
//   err_cnt    out  8          only when BCD_ERR_CNT_EN defined (see CONFIGURATION)
// BEHAVIOUR
//   Reset (rst_n=0 at edge): state=COLLECT, out_word=0, out_count=0, out_err=0,
//     out_valid=0, err_cnt=0; in_ready=1 the cycle after. Reset mid-frame discards it.
//   FSM: COLLECT -> HOLD when accepted digit is the NDIG-th OR in_last=1.
//        HOLD -> COLLECT on out_valid&&out_ready. No other transitions.
//   in_ready = (state==COLLECT); out_valid = (state==HOLD). Both registered-state driven.
//   Accept = in_valid&&in_ready: out_word <= {out_word[4*NDIG-5:0], d}; out_count++.
//     d = in_digit if in_digit<=9, else 4'h0 and out_err <= 1 (sticky for frame).
//   Latency: out_valid high the cycle after the accepting edge of the closing digit.
//   Short frame (in_last before NDIG): word right-aligned, unused upper digits = 0.
//   in_last on NDIG-th digit: single frame close (no empty frame).
//   in_last with in_valid=0: ignored. in_valid in HOLD: not accepted, input must hold.
//   HOLD: out_word/out_count/out_err stable until handshake; on handshake edge all
//     cleared to 0 and state=COLLECT, so in_ready rises next cycle (no same-cycle
//     accept). Min frame period = digits+1 cycles.
//   out_count never exceeds NDIG; no wrap.
// CONFIGURATION
//   BCD_ERR_CNT_EN defined: port err_cnt present; +1 per accepted invalid digit,
//     saturates at 8'hFF, cleared only by reset.
//   Not defined: err_cnt port and counter absent; all other behaviour identical.
// STRUCTURE
//   Package bcd_pkg: typedef logic [3:0] bcd_digit_t; localparam BCD_MAX=4'd9;
//     typedef enum {COLLECT, HOLD} pack_state_t.
//   Sub-module bcd_digit_check: combinational, in bcd_digit_t -> ok flag (<=BCD_MAX).
//   Packer holds FSM, shift register, counter, sticky err, optional err_cnt.
// TESTING
//   1 Full frame NDIG=4: digits 1,2,3,4 back-to-back, out_ready=1 -> out_word=16'h1234,
//     out_count=4, out_err=0; out_valid 1 cycle after 4th accept, for 1 cycle.
//   2 Short frame: 9,8 with in_last on 8 -> out_word=16'h0098, out_count=2.
//   3 Invalid digit: 5,4'hC,7 last -> out_word=16'h0507, out_err=1; with
//     BCD_ERR_CNT_EN err_cnt=1; next clean frame out_err=0, err_cnt stays 1.
//   4 Backpressure: out_ready=0 for 5 cycles in HOLD -> in_ready=0, word stable,
//     held in_valid digit accepted only after handshake + 1 cycle.
//   5 Reset mid-frame: 2 digits then rst_n=0 one cycle -> all outputs 0; next frame
//     6,1 last -> 16'h0061, out_count=2.
//   6 Saturation (BCD_ERR_CNT_EN): 300 invalid digits -> err_cnt=8'hFF.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared types for the BCD digit packing path: digit type, range limit and packer states.
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX = 4'd9;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } pack_state_t;

endpackage

// File: rtl/bcd_digit_check.sv
// Combinational range check for one 8421 digit: ok is high when the digit is 0..9.
module bcd_digit_check
    import bcd_pkg::*;
(
    input  bcd_digit_t digit,
    output logic       ok
);

    assign ok = (digit <= BCD_MAX);

endmodule

// File: rtl/bcd_digit_packer.sv
// Packs a valid/ready stream of BCD digits into one word per frame, MS digit first.
// Define BCD_ERR_CNT_EN to add the saturating err_cnt port counting invalid digits.
module bcd_digit_packer
    import bcd_pkg::*;
#(
    parameter int NDIG = 4,
    parameter int CW   = $clog2(NDIG + 1)
)
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [3:0]          in_digit,
    input  logic                in_valid,
    input  logic                in_last,
    output logic                in_ready,
    output logic [4*NDIG-1:0]   out_word,
    output logic [CW-1:0]       out_count,
    output logic                out_err,
    output logic                out_valid,
    input  logic                out_ready
`ifdef BCD_ERR_CNT_EN
    ,
    output logic [7:0]          err_cnt
`endif
);

    pack_state_t         state_q, state_d;
    logic [4*NDIG-1:0]   word_q, word_d;
    logic [CW-1:0]       count_q, count_d;
    logic                err_q, err_d;

    logic                dig_ok;
    logic                accept;
    logic                last_slot;
    bcd_digit_t          digit_in;
    logic [4*NDIG-1:0]   digit_ext;

    bcd_digit_check u_check (
        .digit (in_digit),
        .ok    (dig_ok)
    );

    assign accept    = in_valid && (state_q == COLLECT);
    assign last_slot = (count_q == CW'(NDIG - 1));

    always_comb begin
        state_d   = state_q;
        word_d    = word_q;
        count_d   = count_q;
        err_d     = err_q;
        // Out-of-range digits are stored as zero; the frame error flag records them.
        digit_in  = dig_ok ? in_digit : 4'h0;
        digit_ext = '0;
        digit_ext[3:0] = digit_in;

        case (state_q)
            COLLECT: begin
                if (in_valid) begin
                    word_d  = (word_q << 4) | digit_ext;
                    count_d = count_q + CW'(1);
                    if (!dig_ok) begin
                        err_d = 1'b1;
                    end
                    if (last_slot || in_last) begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    word_d  = '0;
                    count_d = '0;
                    err_d   = 1'b0;
                    state_d = COLLECT;
                end
            end
            default: begin
                state_d = COLLECT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= COLLECT;
            word_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    assign in_ready  = (state_q == COLLECT);
    assign out_valid = (state_q == HOLD);
    assign out_word  = word_q;
    assign out_count = count_q;
    assign out_err   = err_q;

`ifdef BCD_ERR_CNT_EN
    logic [7:0] errcnt_q, errcnt_d;

    // Lifetime count of invalid digits; survives frame boundaries, sticks at 255.
    always_comb begin
        errcnt_d = errcnt_q;
        if (accept && !dig_ok && (errcnt_q != 8'hFF)) begin
            errcnt_d = errcnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            errcnt_q <= 8'h00;
        end else begin
            errcnt_q <= errcnt_d;
        end
    end

    assign err_cnt = errcnt_q;
`else
    logic unused_accept;
    assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_bcd_digit_packer.sv
// Randomized and directed bench for bcd_digit_packer against a frame-level queue model.
module tb_bcd_digit_packer;

    localparam int NDIG = 4;
    localparam int CW   = $clog2(NDIG + 1);

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [3:0]        in_digit = 4'h0;
    logic              in_valid = 1'b0;
    logic              in_last = 1'b0;
    logic              in_ready;
    logic [4*NDIG-1:0] out_word;
    logic [CW-1:0]     out_count;
    logic              out_err;
    logic              out_valid;
    logic              out_ready = 1'b0;
`ifdef BCD_ERR_CNT_EN
    logic [7:0]        err_cnt;
`endif

    bcd_digit_packer #(.NDIG(NDIG)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_digit  (in_digit),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_word  (out_word),
        .out_count (out_count),
        .out_err   (out_err),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef BCD_ERR_CNT_EN
        ,
        .err_cnt   (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference: digits of the current frame in arrival order, plus frame flags.
    int m_q[$];
    bit m_hold   = 1'b0;
    bit m_err    = 1'b0;
    int m_errcnt = 0;
    bit m_acc    = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_word();
        logic [31:0] w = 0;
        foreach (m_q[i]) w = w * 16 + m_q[i];
        return w;
    endfunction

    task automatic cyc();
        @(posedge clk);
        m_acc = 1'b0;
        if (!rst_n) begin
            m_q.delete();
            m_hold   = 1'b0;
            m_err    = 1'b0;
            m_errcnt = 0;
        end else if (m_hold) begin
            if (out_ready) begin
                m_q.delete();
                m_hold = 1'b0;
                m_err  = 1'b0;
            end
        end else if (in_valid) begin
            m_acc = 1'b1;
            if (in_digit > 9) begin
                m_q.push_back(0);
                m_err = 1'b1;
                if (m_errcnt < 255) m_errcnt++;
            end else begin
                m_q.push_back(int'(in_digit));
            end
            if (m_q.size() == NDIG || in_last) m_hold = 1'b1;
        end
        #1;
        chk("in_ready",  in_ready,  !m_hold);
        chk("out_valid", out_valid, m_hold);
        chk("out_word",  out_word,  exp_word());
        chk("out_count", out_count, m_q.size());
        chk("out_err",   out_err,   m_err);
`ifdef BCD_ERR_CNT_EN
        chk("err_cnt",   err_cnt,   m_errcnt);
`endif
    endtask

    task automatic send_digit(input logic [3:0] d, input logic last);
        bit done = 1'b0;
        in_digit = d;
        in_last  = last;
        in_valid = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            cyc();
            done = m_acc;
        end
        if (!done) chk("accept_timeout", 0, 1);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        cyc();
        cyc();
        chk("rst_word", out_word, 0);
        chk("rst_ready", in_ready, 1);
        rst_n = 1'b1;

        // Full frame, back-to-back.
        out_ready = 1'b1;
        send_digit(4'd1, 1'b0);
        send_digit(4'd2, 1'b0);
        send_digit(4'd3, 1'b0);
        send_digit(4'd4, 1'b0);
        chk("t1_word",  out_word,  16'h1234);
        chk("t1_count", out_count, 4);
        chk("t1_err",   out_err,   0);
        chk("t1_vld",   out_valid, 1);
        cyc();
        chk("t1_vld_drop", out_valid, 0);

        // Short frame.
        send_digit(4'd9, 1'b0);
        send_digit(4'd8, 1'b1);
        chk("t2_word",  out_word,  16'h0098);
        chk("t2_count", out_count, 2);
        cyc();

        // Invalid digit in the middle.
        send_digit(4'd5, 1'b0);
        send_digit(4'hC, 1'b0);
        send_digit(4'd7, 1'b1);
        chk("t3_word", out_word, 16'h0507);
        chk("t3_err",  out_err,  1);
`ifdef BCD_ERR_CNT_EN
        chk("t3_cnt", err_cnt, 1);
`endif
        cyc();
        send_digit(4'd3, 1'b1);
        chk("t3_clean_err", out_err, 0);
`ifdef BCD_ERR_CNT_EN
        chk("t3_cnt_keep", err_cnt, 1);
`endif
        cyc();

        // Backpressure with a digit waiting.
        out_ready = 1'b0;
        send_digit(4'd4, 1'b0);
        send_digit(4'd3, 1'b0);
        send_digit(4'd2, 1'b0);
        send_digit(4'd1, 1'b0);
        in_digit = 4'd6;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("t4_ready_low", in_ready, 0);
            chk("t4_word_hold", out_word, 16'h4321);
        end
        out_ready = 1'b1;
        cyc();
        chk("t4_hs_count", out_count, 0);
        cyc();
        chk("t4_late_acc", out_count, 1);
        chk("t4_late_word", out_word, 16'h0006);
        in_valid = 1'b0;
        send_digit(4'd0, 1'b1);
        cyc();

        // Reset in the middle of a frame.
        send_digit(4'd2, 1'b0);
        send_digit(4'd3, 1'b0);
        rst_n = 1'b0;
        cyc();
        chk("t5_rst_count", out_count, 0);
        chk("t5_rst_word",  out_word,  0);
        rst_n = 1'b1;
        send_digit(4'd6, 1'b0);
        send_digit(4'd1, 1'b1);
        chk("t5_word",  out_word,  16'h0061);
        chk("t5_count", out_count, 2);
        cyc();

`ifdef BCD_ERR_CNT_EN
        // Saturation of the lifetime error counter.
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        for (int i = 0; i < 300; i++) begin
            send_digit(4'hF, 1'b1);
            cyc();
        end
        chk("t6_sat", err_cnt, 8'hFF);
`endif

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            rst_n     = ($urandom_range(0, 199) != 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_digit  = 4'($urandom_range(0, 11));
            in_last   = ($urandom_range(0, 3) == 0);
            out_ready = ($urandom_range(0, 1) == 1);
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
